sm3_msg_pad: RTL and testbench

// Producer side of the 512-bit block interface consumed by SM3 message expansion.
// - Accepts an arbitrary-length byte message as a stream of 32-bit big-endian words.
// - Applies SM3 padding: a 0x80 byte, zero bytes, then the 64-bit big-endian bit length.
// - Emits one or more 512-bit blocks via a valid/ready handshake.
// - Tags each block with first/last so the compression stage can load the IV or finalise.

---
 rtl/sm3_msg_pad.sv | 145 ++++++++++++++
 tb/tb_sm3_msg_pad.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sm3_msg_pad.sv
// SM3 message padder: packs a big-endian 32-bit word stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and tags first/last blocks.
module sm3_msg_pad #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  // Handshakes: a word moves when in_valid && in_ready, a block when
  // blk_valid && blk_ready; the two are never offered in the same cycle.
  typedef enum logic [1:0] {IDLE, FILL, PAD, OUT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             fin_q, fin_d;
  logic             pend_q, pend_d;
  logic             tail_q, tail_d;
  logic             fit_q, fit_d;
  logic [31:0]      buf_q [16];
  logic [31:0]      buf_d [16];

  logic             acc;
  logic [4:0]       sh;
  logic [31:0]      tail_word;
  logic [63:0]      len64;

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == OUT);
  assign blk_first = blk_valid && first_q;
  assign blk_last  = blk_valid && fin_q;
  assign acc       = in_valid && in_ready;
  assign sh        = {in_bytes[1:0], 3'b000};
  assign len64     = 64'(cnt_q);
  // Keep the valid leading bytes, put 0x80 right after them, zero the rest.
  assign tail_word = (in_data & ~(32'hFFFF_FFFF >> sh)) | (32'h8000_0000 >> sh);

  always_comb begin
    for (int i = 0; i < 16; i++) blk_data[480-32*i +: 32] = buf_q[i];
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    fin_d   = fin_q;
    pend_d  = pend_q;
    tail_d  = tail_q;
    fit_d   = fit_q;
    for (int i = 0; i < 16; i++) buf_d[i] = buf_q[i];

    unique case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (acc) begin
          buf_d[widx_q] = (in_last && !in_bytes[2]) ? tail_word : in_data;
          cnt_d  = cnt_q + LEN_W'({in_bytes, 3'b000});
          widx_d = widx_q + 4'd1;
          if (in_last) begin
            tail_d = 1'b1;
            pend_d = in_bytes[2];
            // Length fits in this block only if the 0x80 word still leaves words 14/15.
            fit_d  = (5'(widx_q) + 5'd1 + 5'(in_bytes[2])) <= 5'd14;
            fin_d  = 1'b0;
            state_d = (widx_q == 4'd15) ? OUT : PAD;
          end else if (widx_q == 4'd15) begin
            fin_d   = 1'b0;
            state_d = OUT;
          end
        end
      end
      PAD: begin
        if (pend_q)                        buf_d[widx_q] = 32'h8000_0000;
        else if (fit_q && widx_q == 4'd14) buf_d[widx_q] = len64[63:32];
        else if (fit_q && widx_q == 4'd15) buf_d[widx_q] = len64[31:0];
        else                               buf_d[widx_q] = 32'h0;
        pend_d = 1'b0;
        widx_d = widx_q + 4'd1;
        if (widx_q == 4'd15) begin
          fin_d   = fit_q;
          state_d = OUT;
        end
      end
      OUT: begin
        if (blk_ready) begin
          first_d = 1'b0;
          widx_d  = 4'd0;
          if (fin_q) begin
            state_d = FILL;
            cnt_d   = '0;
            first_d = 1'b1;
            tail_d  = 1'b0;
          end else if (tail_q) begin
            state_d = PAD;
            fit_d   = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      widx_q  <= 4'd0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      fin_q   <= 1'b0;
      pend_q  <= 1'b0;
      tail_q  <= 1'b0;
      fit_q   <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      fin_q   <= fin_d;
      pend_q  <= pend_d;
      tail_q  <= tail_d;
      fit_q   <= fit_d;
      for (int i = 0; i < 16; i++) buf_q[i] <= buf_d[i];
    end
  end

  a_legal_bytes : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> (in_bytes <= 3'd4 && (in_bytes != 3'd0 || in_last)));

endmodule

// File: tb/tb_sm3_msg_pad.sv
// Directed bench for sm3_msg_pad: hand-computed SM3 padding blocks,
// back-pressure hold, and reset in the middle of a message.
module tb_sm3_msg_pad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int n_pass = 0;
  int n_chk  = 0;

  sm3_msg_pad #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int i, input logic [31:0] v);
    put = b;
    put[480-32*i +: 32] = v;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    in_valid = 1'b1; in_data = d; in_bytes = nb; in_last = last;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("send_timeout", 512'(n >= 100), 512'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_block(input string tag, input logic [511:0] exp, input logic ef,
                           input logic el, input int hold, output int lat);
    logic [511:0] snap;
    lat = 0;
    while (!blk_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_timeout"}, 512'(lat >= 100), 512'(0));
    chk({tag, "_data"}, blk_data, exp);
    chk({tag, "_first"}, 512'(blk_first), 512'(ef));
    chk({tag, "_last"}, 512'(blk_last), 512'(el));
    snap = blk_data;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 512'(blk_valid), 512'(1));
      chk({tag, "_hold_data"}, blk_data, snap);
      chk({tag, "_hold_inready"}, 512'(in_ready), 512'(0));
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    chk({tag, "_valid_drop"}, 512'(blk_valid), 512'(0));
  endtask

  initial begin
    logic [511:0] e1, e2, abc_blk;
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0; blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_data", blk_data, 512'(0));
    chk("rst_first_last", 512'({blk_first, blk_last}), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("fill_in_ready", 512'(in_ready), 512'(1));

    // "abc": 15 cycles from the last accept to blk_valid
    abc_blk = put(put(512'(0), 0, 32'h6162_6380), 15, 32'h0000_0018);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    get_block("t1", abc_blk, 1'b1, 1'b1, 0, lat);
    chk("t1_latency", 512'(lat), 512'(15));

    // empty message
    e1 = put(512'(0), 0, 32'h8000_0000);
    send_word(32'h0000_0000, 3'd0, 1'b1);
    get_block("t2", e1, 1'b1, 1'b1, 0, lat);

    // 64 bytes: full block then a length-only block starting with 0x80
    e1 = '0;
    for (int i = 0; i < 16; i++) e1 = put(e1, i, 32'h6162_6364);
    for (int i = 0; i < 16; i++) send_word(32'h6162_6364, 3'd4, i == 15);
    get_block("t3a", e1, 1'b1, 1'b0, 0, lat);
    chk("t3a_latency", 512'(lat), 512'(0));
    e2 = put(put(512'(0), 0, 32'h8000_0000), 15, 32'h0000_0200);
    get_block("t3b", e2, 1'b0, 1'b1, 0, lat);

    // 56 bytes: 0x80 lands in word 14, length spills to a second block
    e1 = '0;
    for (int i = 0; i < 14; i++) e1 = put(e1, i, 32'hC0DE_0000 | i);
    e1 = put(e1, 14, 32'h8000_0000);
    for (int i = 0; i < 14; i++) send_word(32'hC0DE_0000 | i, 3'd4, i == 13);
    get_block("t4a", e1, 1'b1, 1'b0, 0, lat);
    e2 = put(512'(0), 15, 32'h0000_01C0);
    get_block("t4b", e2, 1'b0, 1'b1, 0, lat);

    // 55 bytes: pad byte fills word 13, length fits in the same block
    e1 = '0;
    for (int i = 0; i < 13; i++) e1 = put(e1, i, 32'hC0DE_0000 | i);
    e1 = put(e1, 13, 32'hAABB_CC80);
    e1 = put(e1, 15, 32'h0000_01B8);
    for (int i = 0; i < 13; i++) send_word(32'hC0DE_0000 | i, 3'd4, 1'b0);
    send_word(32'hAABB_CCDD, 3'd3, 1'b1);
    get_block("t4c", e1, 1'b1, 1'b1, 0, lat);

    // back-pressure: block held 10 cycles while a new word waits at the input
    send_word(32'h6162_6300, 3'd3, 1'b1);
    lat = 0;
    while (!blk_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b1; in_data = 32'h6162_6300; in_bytes = 3'd3; in_last = 1'b1;
    get_block("t5a", abc_blk, 1'b1, 1'b1, 10, lat);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    get_block("t5b", abc_blk, 1'b1, 1'b1, 0, lat);

    // reset after 7 words discards the partial block
    for (int i = 0; i < 7; i++) send_word(32'hDEAD_0000 | i, 3'd4, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_valid", 512'(blk_valid), 512'(0));
    chk("t6_rst_data", blk_data, 512'(0));
    rst_n = 1'b1;
    send_word(32'h6162_6300, 3'd3, 1'b1);
    get_block("t6", abc_blk, 1'b1, 1'b1, 0, lat);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
